multicycle_core: RTL and testbench
==================================

# multicycle_core

Multicycle MIPS-subset processor core: one FSM-sequenced datapath with internal register file, ALU, and a single shared instruction/data memory port with a ready handshake. It succeeds the single-cycle datapath: one memory port instead of separate imem/dmem, a variable-latency memory, parametrised data and address widths, and an illegal-opcode trap. It sits between the testbench or SoC top and one unified memory model.

## Interface
- WIDTH, 32: data/register width. Must be 32 for the ISA encodings below.
- ADDRWIDTH, 8: memory byte-address and PC width. Range 2..32.
- NREGS, 32: register count, fixed at 32 (5-bit specifiers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDRWIDTH  byte address; bits [1:0] always 0 for PC fetches.
- mem_wdata  out  WIDTH  store data; valid while mem_req & mem_we.
- mem_rdata  in  WIDTH  read data; sampled only in the cycle mem_ready=1.
- mem_ready  in  1  completes the current request in the same cycle.
- pc  out  ADDRWIDTH  current PC.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- trap  out  1  sticky illegal-opcode flag.

## Operation
- Supported: R-type op 000000 with funct add 100000, sub 100010, and 100100, or 100101, slt 101010; lw 100011; sw 101011; beq 000100; addi 001000; j 000010. Any other op, or R-type with other funct, is illegal.
- ALU control codes: add 010, sub 110, and 000, or 001, slt 111. slt is signed; result is 1 or 0. The zero flag means the ALU result is 0.
- Internal registers: PC, IR, MDR, A, B, ALUOut, and a 32xWIDTH register file. Register 0 always reads 0, and writes to it are discarded.
- Immediates are sign-extended from 16 bits. Branch target = PC+4 + (simm<<2). Jump target = {(PC+4)[31:28], instr[25:0], 2'b00}. All address arithmetic is done at 32 bits and then truncated to ADDRWIDTH, so wrap-around is modulo 2^ADDRWIDTH.
- FSM states and transitions:
  - FETCH: mem_req=1, we=0, addr=PC. Hold until mem_ready. On ready: IR<=rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=branch target. Dispatch by opcode: lw/sw -> MEMADR, R -> EXECUTE, beq -> BRANCH, addi -> ADDIEX, j -> JUMP, illegal -> TRAP.
  - MEMADR: ALUOut<=A+simm. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: read at ALUOut. Hold until ready, then MDR<=rdata and go to MEMWB.
  - MEMWB: rf[rt]<=MDR, then FETCH.
  - MEMWR: write B to ALUOut. Hold until ready, then FETCH.
  - EXECUTE: ALUOut<=A op B, then ALUWB.
  - ALUWB: rf[rd]<=ALUOut, then FETCH.
  - BRANCH: compute A-B; if zero, PC<=ALUOut. Then FETCH.
  - ADDIEX: ALUOut<=A+simm, then ADDIWB.
  - ADDIWB: rf[rt]<=ALUOut, then FETCH.
  - JUMP: PC<=jump target, then FETCH.
  - TRAP: trap<=1, no memory requests. Held until reset; PC stays at the value after the faulting fetch.
- instr_done pulses in the final cycle of each instruction: MEMWB, the MEMWR ready cycle, ALUWB, BRANCH, ADDIWB, JUMP. It never pulses for a trapped instruction.
- Memory write side effect: mem_we=1 only in MEMWR. mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.

## Timing
- Reset applies at the clock edge while rst=1. On reset: PC=0, state=FETCH, all registers including IR, MDR, A, B, ALUOut and the register file =0, trap=0, instr_done=0.
- mem_req is a Moore output, so it is high in the first cycle after reset release.
- rst asserted mid-instruction aborts it at the next edge. No register-file write or PC update from the aborted instruction occurs at that edge.
- Latency with mem_ready tied to 1 (cycles, including fetch): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle on a memory state adds 1.
- mem_ready while mem_req=0 is ignored.
- Back-to-back: FETCH of the next instruction starts the cycle after the retiring cycle. There is no overlap between instructions.

## Test plan
- Reset then program `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2`, with ready=1 -> rf[3]=2. Cycles from reset release to the third instr_done = 12.
- `sw $1,0x10($0)` then `lw $4,0x10($0)` with ready delayed 3 cycles on every request -> write seen at addr 0x10 with data 5, rf[4]=5, and addr/we/wdata stable during the waits.
- `beq $1,$1,-1` at PC 0x08 -> next fetch at 0x08. `beq` with unequal operands -> next fetch at 0x0C. With ADDRWIDTH=8, a branch from PC 0xFC with offset +1 -> next fetch at 0x04 (wrap).
- `slt` with $1=-1, $2=1 -> 1; reversed operands -> 0. `addi $0,$0,7` -> rf[0] still reads 0.
- Opcode 0x3F at PC 0x04 -> trap=1 in the DECODE+1 cycle, mem_req stays 0, no instr_done; rst clears trap and the next fetch is at PC 0.
- rst pulsed in the MEMWB cycle of lw -> destination register unchanged (0), PC=0.

Source files
------------

// File: rtl/multicycle_core.sv
// multicycle_core: FSM-sequenced MIPS-subset datapath with one
// shared instruction/data memory port and a sticky illegal-op trap.
module multicycle_core #(
  parameter int WIDTH     = 32,
  parameter int ADDRWIDTH = 8,
  parameter int NREGS     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata,
  input  logic                 mem_ready,
  output logic [ADDRWIDTH-1:0] pc,
  output logic                 instr_done,
  output logic                 trap
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_TRAP
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] mdr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] rf [NREGS];

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [WIDTH-1:0] simm;
  logic [WIDTH-1:0] pc_ext;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;

  logic [2:0] alu_ctl;
  logic       funct_ok;

  logic                 ir_en;
  logic                 pc_en;
  logic [ADDRWIDTH-1:0] pc_nxt;
  logic                 mdr_en;
  logic                 ab_en;
  logic                 ao_en;
  logic [WIDTH-1:0]     ao_nxt;
  logic                 rf_we;
  logic [4:0]           rf_wa;
  logic [WIDTH-1:0]     rf_wd;
  logic                 trap_set;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign simm   = {{(WIDTH-16){ir[15]}}, ir[15:0]};
  assign pc_ext = WIDTH'(pc);

  // pc already holds PC+4 once the fetch has completed
  assign br_target = pc_ext + (simm << 2);
  assign j_target  = {pc_ext[31:28], ir[25:0], 2'b00};

  assign rf_a = (rs == 5'd0) ? '0 : rf[rs];
  assign rf_b = (rt == 5'd0) ? '0 : rf[rt];

  function automatic logic [WIDTH-1:0] alu_f(
    input logic [2:0]       ctl,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (ctl)
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SUB: r = x - y;
      ALU_SLT: r = WIDTH'($signed(x) < $signed(y));
      default: r = x + y;
    endcase
    return r;
  endfunction

  always_comb begin
    alu_ctl  = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: alu_ctl = ALU_ADD;
      6'b100010: alu_ctl = ALU_SUB;
      6'b100100: alu_ctl = ALU_AND;
      6'b100101: alu_ctl = ALU_OR;
      6'b101010: alu_ctl = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    instr_done = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_nxt     = pc;
    mdr_en     = 1'b0;
    ab_en      = 1'b0;
    ao_en      = 1'b0;
    ao_nxt     = alu_out;
    rf_we      = 1'b0;
    rf_wa      = rt;
    rf_wd      = alu_out;
    trap_set   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          pc_nxt  = ADDRWIDTH'(pc_ext + WIDTH'(4));
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_en  = 1'b1;
        ao_en  = 1'b1;
        ao_nxt = br_target;
        unique case (1'b1)
          (op == OP_LW || op == OP_SW): state_n = S_MEMADR;
          (op == OP_R && funct_ok):     state_n = S_EXECUTE;
          (op == OP_BEQ):               state_n = S_BRANCH;
          (op == OP_ADDI):              state_n = S_ADDIEX;
          (op == OP_J):                 state_n = S_JUMP;
          default: begin
            trap_set = 1'b1;
            state_n  = S_TRAP;
          end
        endcase
      end
      S_MEMADR: begin
        ao_en   = 1'b1;
        ao_nxt  = alu_f(ALU_ADD, a, simm);
        state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          mdr_en  = 1'b1;
          state_n = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        rf_wd      = mdr;
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_n    = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ao_en   = 1'b1;
        ao_nxt  = alu_f(alu_ctl, a, b);
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we      = 1'b1;
        rf_wa      = rd;
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_BRANCH: begin
        if (alu_f(ALU_SUB, a, b) == '0) begin
          pc_en  = 1'b1;
          pc_nxt = ADDRWIDTH'(alu_out);
        end
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_ADDIEX: begin
        ao_en   = 1'b1;
        ao_nxt  = alu_f(ALU_ADD, a, simm);
        state_n = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we      = 1'b1;
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_JUMP: begin
        pc_en      = 1'b1;
        pc_nxt     = ADDRWIDTH'(j_target);
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_TRAP: begin
        state_n = S_TRAP;
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

  // Data-side states address through ALUOut, everything else through PC
  assign mem_addr  = (state == S_MEMRD || state == S_MEMWR) ?
                     ADDRWIDTH'(alu_out) : pc;
  assign mem_wdata = b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= '0;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      trap    <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      state <= state_n;
      if (ir_en) begin
        ir <= mem_rdata;
      end
      if (pc_en) begin
        pc <= pc_nxt;
      end
      if (mdr_en) begin
        mdr <= mem_rdata;
      end
      if (ab_en) begin
        a <= rf_a;
        b <= rf_b;
      end
      if (ao_en) begin
        alu_out <= ao_nxt;
      end
      if (trap_set) begin
        trap <= 1'b1;
      end
      if (rf_we && rf_wa != 5'd0) begin
        rf[rf_wa] <= rf_wd;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed checks plus random programs compared
// against an instruction-level model of the MIPS subset.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [7:0]  pc;
  logic        instr_done;
  logic        trap;

  always #5 clk = ~clk;

  multicycle_core #(
    .WIDTH(32),
    .ADDRWIDTH(8),
    .NREGS(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc(pc),
    .instr_done(instr_done),
    .trap(trap)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // memory model: img is staged by the test, copied into mem at reset
  logic [31:0] img [64];
  logic [31:0] mem [64];
  logic        load = 1'b0;
  int          lat_fix = 0;
  int          lat_cur = 0;
  int          wcnt = 0;
  logic        junk = 1'b0;
  int          wr_cnt = 0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  int          stab_err = 0;
  logic        p_wait = 1'b0;
  logic [7:0]  p_addr = '0;
  logic        p_we = 1'b0;
  logic [31:0] p_wdata = '0;

  assign mem_rdata = mem[mem_addr[7:2]];
  assign mem_ready = mem_req ? (wcnt >= lat_cur) : junk;

  function automatic int pick_lat();
    return (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
  endfunction

  always @(posedge clk) begin
    junk <= 1'($urandom_range(0, 1));
    if (p_wait && mem_req &&
        (mem_addr !== p_addr || mem_we !== p_we ||
         (mem_we && mem_wdata !== p_wdata)))
      stab_err <= stab_err + 1;
    p_wait  <= mem_req && !mem_ready && !rst;
    p_addr  <= mem_addr;
    p_we    <= mem_we;
    p_wdata <= mem_wdata;
    if (load) begin
      mem      <= img;
      wr_cnt   <= 0;
      stab_err <= 0;
    end
    if (rst || load) begin
      wcnt    <= 0;
      lat_cur <= pick_lat();
    end else if (mem_req && mem_ready) begin
      if (mem_we) begin
        mem[mem_addr[7:2]] <= mem_wdata;
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end
      wcnt    <= 0;
      lat_cur <= pick_lat();
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end
  end

  // instruction-level reference model
  logic [31:0] m_mem [64];
  logic [31:0] m_reg [32];
  logic [7:0]  m_pc;

  task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  task automatic m_step(output bit ill);
    logic [31:0] ins, simm, va, vb, r;
    logic [7:0]  ad;
    ins  = m_mem[m_pc[7:2]];
    simm = {{16{ins[15]}}, ins[15:0]};
    va   = m_reg[ins[25:21]];
    vb   = m_reg[ins[20:16]];
    ad   = 8'(va + simm);
    r    = 0;
    ill  = 0;
    m_pc = m_pc + 8'd4;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20: r = va + vb;
          6'h22: r = va - vb;
          6'h24: r = va & vb;
          6'h25: r = va | vb;
          6'h2A: r = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          default: ill = 1;
        endcase
        if (!ill) m_wr(ins[15:11], r);
      end
      6'h08: m_wr(ins[20:16], va + simm);
      6'h23: m_wr(ins[20:16], m_mem[ad[7:2]]);
      6'h2B: m_mem[ad[7:2]] = vb;
      6'h04: if (va == vb) m_pc = m_pc + 8'(simm << 2);
      6'h02: m_pc = {ins[5:0], 2'b00};
      default: ill = 1;
    endcase
  endtask

  function automatic logic [31:0] ei(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] ej(input logic [25:0] idx);
    return {6'b000010, idx};
  endfunction

  localparam logic [31:0] ILL = 32'hFC00_0000;

  task automatic check(input string tag, input logic [31:0] obs,
    input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
  endtask

  task automatic start(input int lat);
    lat_fix = lat;
    for (int i = 0; i < 64; i++) m_mem[i] = img[i];
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_pc = 8'h0;
    do_reset();
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!instr_done && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (!instr_done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_trap(input string tag);
    int c = 0;
    while (!trap && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_trap"}, 32'(trap), 32'd1);
  endtask

  task automatic run_random(input int n);
    bit ill, pend;
    int nbad, k, kind;
    logic [4:0] ra, rb, rc;
    logic [5:0] fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
    fns[3] = 6'h25; fns[4] = 6'h2A;
    clear_img();
    for (int i = 32; i < 64; i++) img[i] = $urandom;
    for (int i = 0; i < n - 1; i++) begin
      ra   = 5'($urandom_range(0, 7));
      rb   = 5'($urandom_range(0, 7));
      rc   = 5'($urandom_range(0, 7));
      kind = $urandom_range(0, 8);
      case (kind)
        0: img[i] = ei(6'h08, ra, rb, 16'($urandom));
        6: img[i] = ei(6'h2B, 5'd0, rb,
                       16'(128 + 4 * $urandom_range(0, 31)));
        7: img[i] = ei(6'h23, 5'd0, rb,
                       16'(128 + 4 * $urandom_range(0, 31)));
        8: begin
          k = $urandom_range(0, 3);
          if (i + 1 + k > n - 1) k = n - 2 - i;
          img[i] = ei(6'h04, ra, rb, 16'(k));
        end
        default: img[i] = er(ra, rb, rc, fns[kind-1]);
      endcase
    end
    img[n-1] = ILL;
    start(-1);
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (pend) begin
        check("rnd_pc", 32'(pc), 32'(m_pc));
        pend = 0;
      end
      if (trap) break;
      if (instr_done) begin
        m_step(ill);
        pend = 1;
      end
    end
    check("rnd_trap", 32'(trap), 32'd1);
    m_step(ill);
    check("rnd_ill", 32'(ill), 32'd1);
    check("rnd_trap_pc", 32'(pc), 32'(m_pc));
    for (int r = 0; r < 8; r++) check("rnd_rf", dut.rf[r], m_reg[r]);
    nbad = 0;
    for (int i = 32; i < 64; i++) if (mem[i] !== m_mem[i]) nbad++;
    check("rnd_mem", 32'(nbad), 32'd0);
    check("rnd_stable", 32'(stab_err), 32'd0);
  endtask

  initial begin
    int cyc, nd;
    bit saw_req, saw_done;
    int exp_lat [4];

    // addi/addi/add with ready tied high, plus reset state
    clear_img();
    img[0] = ei(6'h08, 5'd0, 5'd1, 16'd5);
    img[1] = ei(6'h08, 5'd0, 5'd2, 16'hFFFD);
    img[2] = er(5'd1, 5'd2, 5'd3, 6'h20);
    img[3] = ILL;
    start(0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_req", 32'(mem_req), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_done", 32'(instr_done), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    cyc = 1;
    nd  = 0;
    while (cyc < 60) begin
      if (instr_done) nd++;
      if (nd == 3) break;
      @(negedge clk);
      cyc++;
    end
    check("add_cycles", 32'(cyc), 32'd12);
    @(negedge clk);
    check("add_rf3", dut.rf[3], 32'd2);

    // per-class latency with ready tied high
    clear_img();
    img[0]  = ei(6'h23, 5'd0, 5'd5, 16'h0080);
    img[1]  = ei(6'h2B, 5'd0, 5'd5, 16'h0084);
    img[2]  = ei(6'h04, 5'd0, 5'd0, 16'h0000);
    img[3]  = ej(26'd4);
    img[4]  = ILL;
    img[32] = 32'hCAFE_0001;
    exp_lat[0] = 5; exp_lat[1] = 4; exp_lat[2] = 3; exp_lat[3] = 3;
    start(0);
    for (int k = 0; k < 4; k++) begin
      cyc = 1;
      while (!instr_done && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("latency", 32'(cyc), 32'(exp_lat[k]));
      @(negedge clk);
    end

    // sw then lw with three wait cycles on every request
    clear_img();
    img[0] = ei(6'h08, 5'd0, 5'd1, 16'd5);
    img[1] = ei(6'h2B, 5'd0, 5'd1, 16'h0010);
    img[2] = ei(6'h23, 5'd0, 5'd4, 16'h0010);
    img[3] = ILL;
    start(3);
    wait_trap("swlw");
    check("sw_count", 32'(wr_cnt), 32'd1);
    check("sw_addr", 32'(wr_addr), 32'h10);
    check("sw_data", wr_data, 32'd5);
    check("lw_rf4", dut.rf[4], 32'd5);
    check("swlw_stable", 32'(stab_err), 32'd0);

    // taken branch back onto itself at 0x08
    clear_img();
    img[0] = ei(6'h08, 5'd0, 5'd1, 16'd1);
    img[1] = ei(6'h08, 5'd0, 5'd2, 16'd2);
    img[2] = ei(6'h04, 5'd1, 5'd1, 16'hFFFF);
    start(0);
    for (int k = 0; k < 3; k++) begin
      wait_done("beq_self");
      @(negedge clk);
    end
    check("beq_self_addr", 32'(mem_addr), 32'h08);
    check("beq_self_pc", 32'(pc), 32'h08);

    // not-taken branch falls through
    img[2] = ei(6'h04, 5'd1, 5'd2, 16'd5);
    img[3] = ILL;
    start(0);
    for (int k = 0; k < 3; k++) begin
      wait_done("beq_nt");
      @(negedge clk);
    end
    check("beq_nt_addr", 32'(mem_addr), 32'h0C);

    // jump to 0xFC then branch wrapping past the top of memory
    clear_img();
    img[0]  = ej(26'd63);
    img[63] = ei(6'h04, 5'd0, 5'd0, 16'd1);
    img[1]  = ILL;
    start(0);
    wait_done("jump");
    @(negedge clk);
    check("jump_pc", 32'(pc), 32'hFC);
    wait_done("wrap");
    @(negedge clk);
    check("wrap_addr", 32'(mem_addr), 32'h04);

    // signed slt both ways and writes to $0
    clear_img();
    img[0] = ei(6'h08, 5'd0, 5'd1, 16'hFFFF);
    img[1] = ei(6'h08, 5'd0, 5'd2, 16'd1);
    img[2] = er(5'd1, 5'd2, 5'd3, 6'h2A);
    img[3] = er(5'd2, 5'd1, 5'd4, 6'h2A);
    img[4] = ei(6'h08, 5'd0, 5'd0, 16'd7);
    img[5] = ILL;
    start(1);
    wait_trap("slt");
    check("slt_lt", dut.rf[3], 32'd1);
    check("slt_ge", dut.rf[4], 32'd0);
    check("r0_zero", dut.rf[0], 32'd0);

    // illegal opcode at 0x04
    clear_img();
    img[0] = ei(6'h08, 5'd0, 5'd1, 16'd1);
    img[1] = ILL;
    start(0);
    for (int k = 0; k < 5; k++) @(negedge clk);
    check("trap_decode", 32'(trap), 32'd0);
    @(negedge clk);
    check("trap_set", 32'(trap), 32'd1);
    check("trap_pc", 32'(pc), 32'h08);
    saw_req  = 0;
    saw_done = 0;
    for (int k = 0; k < 10; k++) begin
      if (mem_req) saw_req = 1;
      if (instr_done) saw_done = 1;
      @(negedge clk);
    end
    check("trap_noreq", 32'(saw_req), 32'd0);
    check("trap_nodone", 32'(saw_done), 32'd0);
    do_reset();
    check("trap_clr", 32'(trap), 32'd0);
    check("trap_rst_addr", 32'(mem_addr), 32'd0);
    check("trap_rst_req", 32'(mem_req), 32'd1);

    // reset during lw write-back
    clear_img();
    img[0]  = ei(6'h23, 5'd0, 5'd4, 16'h0080);
    img[32] = 32'h0000_1234;
    start(0);
    wait_done("abort");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_rf4", dut.rf[4], 32'd0);
    check("abort_pc", 32'(pc), 32'd0);

    // random programs with random memory latency
    for (int t = 0; t < 4; t++) run_random(24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
